alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter: LINK_REG, default 31, destination register written by JAL.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 in_valid  in  1  instruction offered; in_ready  out  1  dispatcher can accept.
REQ-005 in_instr  in  32  MIPS instruction; in_rs_val, in_rt_val  in  32  register operands; in_pc  in  32  instruction address.
REQ-006 alu_a, alu_b  out  32  ALU operands; alu_op  out  4  ALU opcode (registered).
REQ-007 alu_out  in  32; alu_z, alu_n  in  1  ALU result and zero/negative flags (ALU is combinational, external).
REQ-008 res_valid  out  1; res_ready  in  1  result handshake.
REQ-009 res_data  out  32; res_dest  out  5; res_we  out  1; res_taken  out  1  branch outcome; res_illegal  out  1.

Function
REQ-010 States IDLE, EXEC, DONE; in_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in DONE.
REQ-011 IDLE: in_valid=1 -> latch decoded alu_a/alu_b/alu_op/dest/we/branch kind, go EXEC.
REQ-012 EXEC: lasts exactly one cycle; alu_out/alu_z/alu_n sampled at its closing edge into res_* registers; go DONE.
REQ-013 DONE: res_* held stable while res_ready=0; res_ready=1 -> IDLE; res_valid high first at acceptance edge +2.
REQ-014 ALU opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 sll (A<<B), 7 srl, 8 sra, 9 unsigned A<B, 10 pass A, 11 pass B, 12 B+8.
REQ-015 R-type funct: 0x20/0x21 ->0; 0x22/0x23 ->1; 0x24->2; 0x25->3; 0x26->4; 0x27->5; 0x2B->9; A=rs, B=rt, dest=rd.
REQ-016 Shifts: sll/srl/sra (0x00/0x02/0x03) A=rt, B=zero-extended shamt; sllv/srlv/srav (0x04/0x06/0x07) A=rt, B={27'b0, rs[4:0]}; dest=rd.
REQ-017 JALR (funct 0x09): op 12, B=in_pc, dest=rd.
REQ-018 I-type: addi/addiu (0x08/0x09) op0 sign-extended imm; sltiu (0x0B) op9 sign-extended imm; andi/ori/xori (0x0C/0x0D/0x0E) zero-extended imm; lui (0x0F) op11, B={imm,16'b0}; A=rs, dest=rt.
REQ-019 JAL (0x03): op 12, B=in_pc, dest=LINK_REG.
REQ-020 Branches: beq(0x04)/bne(0x05) op1 A=rs B=rt, taken=Z / !Z; blez(0x06)/bgtz(0x07) op10 A=rs, taken=Z|N / !Z&!N; res_we=0.
REQ-021 res_taken SHALL be 0 for every non-branch instruction.
REQ-022 res_we SHALL be 0 when dest=0, for branches, and for illegal instructions.
REQ-023 Any other opcode/funct: alu_op=0, A=B=0, res_illegal=1, res_data=0, res_we=0.
REQ-024 Arithmetic is 32-bit modulo; no overflow trap for add/sub/addi.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE and zero alu_a, alu_b, alu_op, res_data, res_dest, res_we, res_taken, res_illegal; res_valid=0.
REQ-026 Reset in EXEC or DONE SHALL discard the in-flight instruction; no result is presented.
REQ-027 in_ready SHALL be 0 while reset=0 is sampled and 1 the cycle after release.

Structure
REQ-028 Shared package alu_pkg SHALL hold ALU opcode constants, MIPS opcode/funct constants, and the state enumeration.
REQ-029 Combinational decode SHALL be a sub-module alu_decode (instr, rs_val, rt_val, pc -> a, b, op, dest, we, branch kind, illegal).
REQ-030 Target size 150-300 lines RTL including alu_decode; ALU instantiated at the testbench/top level.

Verification
REQ-031 add rd=3, rs=5, rt=0xFFFFFFFB -> res_data=0, res_we=1, res_dest=3, res_valid at acceptance+2.
REQ-032 beq rs=rt=7 -> res_taken=1, res_we=0; bgtz rs=0x80000000 -> res_taken=0.
REQ-033 sra rt=0x80000000 shamt=4 -> res_data=0xF8000000; lui imm=0x1234 -> 0x12340000.
REQ-034 jal in_pc=0x100 -> res_data=0x108, res_dest=31; sltiu rs=1 imm=0xFFFF -> res_data=1.
REQ-035 res_ready=0 for 5 cycles in DONE -> res_* stable, in_ready=0; undefined funct 0x3F -> res_illegal=1, res_we=0.
REQ-036 reset=0 asserted during EXEC -> no res_valid, all outputs zero, in_ready=1 cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU dispatcher: ALU opcodes, MIPS opcode/funct codes,
// FSM states and branch kinds.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASA = 4'd10;
  localparam logic [3:0] ALU_PASB = 4'd11;
  localparam logic [3:0] ALU_PC8  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ} br_kind_t;

  function automatic logic branch_taken(input br_kind_t kind, input logic z, input logic n);
    case (kind)
      BR_EQ:   return z;
      BR_NE:   return !z;
      BR_LEZ:  return z | n;
      BR_GTZ:  return !z & !n;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Instruction-in / result-out handshake bundle of the ALU dispatcher.
interface alu_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [31:0] in_pc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_dest;
  logic        res_we;
  logic        res_taken;
  logic        res_illegal;

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, in_pc, res_ready,
    input  in_ready, res_valid, res_data, res_dest, res_we, res_taken, res_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, in_pc, res_ready,
    output in_ready, res_valid, res_data, res_dest, res_we, res_taken, res_illegal
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational MIPS decode: selects ALU operands/opcode, destination,
// write enable and branch kind; flags anything unrecognised as illegal.
module alu_decode
  import alu_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] pc,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  op,
  output logic [4:0]  dest,
  output logic        we,
  output br_kind_t    br_kind,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_se;
  logic [31:0] imm_ze;
  logic        writes;
  logic [4:0]  unused_rs_field;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign imm_se = {{16{imm[15]}}, imm};
  assign imm_ze = {16'h0000, imm};
  // rs is delivered already read through in_rs_val
  assign unused_rs_field = instr[25:21];

  always_comb begin
    a       = '0;
    b       = '0;
    op      = ALU_ADD;
    dest    = '0;
    writes  = 1'b0;
    br_kind = BR_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest   = rd_f;
        writes = 1'b1;
        a      = rs_val;
        b      = rt_val;
        case (funct)
          FN_ADD, FN_ADDU: op = ALU_ADD;
          FN_SUB, FN_SUBU: op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_XOR:  op = ALU_XOR;
          FN_NOR:  op = ALU_NOR;
          FN_SLTU: op = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            a  = rt_val;
            b  = {27'b0, shamt};
            op = (funct == FN_SLL) ? ALU_SLL : (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            a  = rt_val;
            b  = {27'b0, rs_val[4:0]};
            op = (funct == FN_SLLV) ? ALU_SLL : (funct == FN_SRLV) ? ALU_SRL : ALU_SRA;
          end
          FN_JALR: begin
            a  = '0;
            b  = pc;
            op = ALU_PC8;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        a      = rs_val;
        dest   = rt_f;
        writes = 1'b1;
        case (opcode)
          OP_SLTIU: begin op = ALU_SLTU; b = imm_se; end
          OP_ANDI:  begin op = ALU_AND;  b = imm_ze; end
          OP_ORI:   begin op = ALU_OR;   b = imm_ze; end
          OP_XORI:  begin op = ALU_XOR;  b = imm_ze; end
          OP_LUI:   begin op = ALU_PASB; b = {imm, 16'h0000}; end
          default:  begin op = ALU_ADD;  b = imm_se; end
        endcase
      end
      OP_JAL: begin
        op     = ALU_PC8;
        b      = pc;
        dest   = LINK_REG;
        writes = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        op      = ALU_SUB;
        a       = rs_val;
        b       = rt_val;
        br_kind = (opcode == OP_BEQ) ? BR_EQ : BR_NE;
      end
      OP_BLEZ, OP_BGTZ: begin
        op      = ALU_PASA;
        a       = rs_val;
        br_kind = (opcode == OP_BLEZ) ? BR_LEZ : BR_GTZ;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      a      = '0;
      b      = '0;
      op     = ALU_ADD;
      dest   = '0;
      writes = 1'b0;
    end
  end

  assign we = writes && (dest != 5'd0);

endmodule

// File: rtl/alu_dispatch.sv
// Three-state dispatcher: latches a decoded instruction, lets the external
// ALU evaluate it for one cycle, then holds the result until accepted.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic           clk,
  input  logic           reset,
  alu_dispatch_if.slave  bus,
  output logic [31:0]    alu_a,
  output logic [31:0]    alu_b,
  output logic [3:0]     alu_op,
  input  logic [31:0]    alu_out,
  input  logic           alu_z,
  input  logic           alu_n
);

  state_t      state_reg, state_next;
  logic        load_en, capture_en;

  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_op;
  logic [4:0]  dec_dest;
  logic        dec_we, dec_illegal;
  br_kind_t    dec_br;

  logic [31:0] alu_a_reg, alu_b_reg;
  logic [3:0]  alu_op_reg;
  logic [4:0]  dest_reg;
  logic        we_reg, illegal_reg;
  br_kind_t    br_reg;
  logic [31:0] res_data_reg;
  logic [4:0]  res_dest_reg;
  logic        res_we_reg, res_taken_reg, res_illegal_reg;

  alu_decode #(.LINK_REG(LINK_REG)) u_decode (
    .instr   (bus.in_instr),
    .rs_val  (bus.in_rs_val),
    .rt_val  (bus.in_rt_val),
    .pc      (bus.in_pc),
    .a       (dec_a),
    .b       (dec_b),
    .op      (dec_op),
    .dest    (dec_dest),
    .we      (dec_we),
    .br_kind (dec_br),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    capture_en = 1'b0;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) begin
        load_en    = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        capture_en = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: if (bus.res_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      dest_reg        <= '0;
      we_reg          <= 1'b0;
      illegal_reg     <= 1'b0;
      br_reg          <= BR_NONE;
      res_data_reg    <= '0;
      res_dest_reg    <= '0;
      res_we_reg      <= 1'b0;
      res_taken_reg   <= 1'b0;
      res_illegal_reg <= 1'b0;
    end else begin
      if (load_en) begin
        alu_a_reg   <= dec_a;
        alu_b_reg   <= dec_b;
        alu_op_reg  <= dec_op;
        dest_reg    <= dec_dest;
        we_reg      <= dec_we;
        illegal_reg <= dec_illegal;
        br_reg      <= dec_br;
      end
      if (capture_en) begin
        res_data_reg    <= illegal_reg ? 32'h0 : alu_out;
        res_dest_reg    <= dest_reg;
        res_we_reg      <= we_reg;
        res_taken_reg   <= branch_taken(br_reg, alu_z, alu_n);
        res_illegal_reg <= illegal_reg;
      end
    end
  end

  assign alu_a           = alu_a_reg;
  assign alu_b           = alu_b_reg;
  assign alu_op          = alu_op_reg;
  // Gated by reset so the dispatcher never advertises readiness mid-reset
  assign bus.in_ready    = reset && (state_reg == ST_IDLE);
  assign bus.res_valid   = (state_reg == ST_DONE);
  assign bus.res_data    = res_data_reg;
  assign bus.res_dest    = res_dest_reg;
  assign bus.res_we      = res_we_reg;
  assign bus.res_taken   = res_taken_reg;
  assign bus.res_illegal = res_illegal_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch with a behavioural combinational ALU.
module tb_alu_dispatch;

  logic        clk;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_z, alu_n;
  int          tests_run;
  int          tests_failed;

  alu_dispatch_if bus ();

  alu_dispatch #(.LINK_REG(5'd31)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .alu_z   (alu_z),
    .alu_n   (alu_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    case (alu_op)
      4'd0:  alu_out = alu_a + alu_b;
      4'd1:  alu_out = alu_a - alu_b;
      4'd2:  alu_out = alu_a & alu_b;
      4'd3:  alu_out = alu_a | alu_b;
      4'd4:  alu_out = alu_a ^ alu_b;
      4'd5:  alu_out = ~(alu_a | alu_b);
      4'd6:  alu_out = alu_a << alu_b[4:0];
      4'd7:  alu_out = alu_a >> alu_b[4:0];
      4'd8:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd9:  alu_out = {31'b0, alu_a < alu_b};
      4'd10: alu_out = alu_a;
      4'd11: alu_out = alu_b;
      4'd12: alu_out = alu_b + 32'd8;
      default: alu_out = 32'h0;
    endcase
  end
  assign alu_z = (alu_out == 32'h0);
  assign alu_n = alu_out[31];

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
    logic        taken;
    logic        illegal;
    logic        is_br;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Architectural MIPS semantics, independent of the ALU opcode mapping
  function automatic exp_t model(input logic [31:0] ins, rs, rt, pc);
    exp_t e;
    logic [31:0] se, ze;
    logic [4:0]  sh;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    sh = ins[10:6];
    e.data = 32'h0; e.dest = 5'd0; e.taken = 1'b0; e.illegal = 1'b0; e.is_br = 1'b0;
    case (ins[31:26])
      6'h00: begin
        e.dest = ins[15:11];
        case (ins[5:0])
          6'h20, 6'h21: e.data = rs + rt;
          6'h22, 6'h23: e.data = rs - rt;
          6'h24: e.data = rs & rt;
          6'h25: e.data = rs | rt;
          6'h26: e.data = rs ^ rt;
          6'h27: e.data = ~(rs | rt);
          6'h2B: e.data = (rs < rt) ? 32'd1 : 32'd0;
          6'h00: e.data = rt << sh;
          6'h02: e.data = rt >> sh;
          6'h03: e.data = $unsigned($signed(rt) >>> sh);
          6'h04: e.data = rt << rs[4:0];
          6'h06: e.data = rt >> rs[4:0];
          6'h07: e.data = $unsigned($signed(rt) >>> rs[4:0]);
          6'h09: e.data = pc + 32'd8;
          default: begin e.illegal = 1'b1; e.dest = 5'd0; end
        endcase
      end
      6'h08, 6'h09: begin e.data = rs + se; e.dest = ins[20:16]; end
      6'h0B: begin e.data = (rs < se) ? 32'd1 : 32'd0; e.dest = ins[20:16]; end
      6'h0C: begin e.data = rs & ze; e.dest = ins[20:16]; end
      6'h0D: begin e.data = rs | ze; e.dest = ins[20:16]; end
      6'h0E: begin e.data = rs ^ ze; e.dest = ins[20:16]; end
      6'h0F: begin e.data = {ins[15:0], 16'h0}; e.dest = ins[20:16]; end
      6'h03: begin e.data = pc + 32'd8; e.dest = 5'd31; end
      6'h04: begin e.is_br = 1'b1; e.taken = (rs == rt); end
      6'h05: begin e.is_br = 1'b1; e.taken = (rs != rt); end
      6'h06: begin e.is_br = 1'b1; e.taken = ($signed(rs) <= 0); end
      6'h07: begin e.is_br = 1'b1; e.taken = ($signed(rs) > 0); end
      default: e.illegal = 1'b1;
    endcase
    e.we = !e.illegal && !e.is_br && (e.dest != 5'd0);
    return e;
  endfunction

  task automatic run(input string name, input logic [31:0] ins, rs, rt, pc, input int hold);
    exp_t e;
    int   fails_before;
    fails_before = tests_failed;
    bus.in_instr  = ins;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
    bus.in_pc     = pc;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 16 && !bus.in_ready; i++) @(negedge clk);
    check({name, ":in_ready"}, 32'(bus.in_ready), 32'd1);
    sb.push_back(model(ins, rs, rt, pc));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, ":valid_early"}, 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check({name, ":res_valid"}, 32'(bus.res_valid), 32'd1);
    e = sb.pop_front();
    if (!e.is_br) check({name, ":data"}, bus.res_data, e.data);
    if (!e.is_br) check({name, ":dest"}, 32'(bus.res_dest), 32'(e.dest));
    check({name, ":we"}, 32'(bus.res_we), 32'(e.we));
    check({name, ":taken"}, 32'(bus.res_taken), 32'(e.taken));
    check({name, ":illegal"}, 32'(bus.res_illegal), 32'(e.illegal));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ":hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({name, ":hold_ready"}, 32'(bus.in_ready), 32'd0);
      if (!e.is_br) check({name, ":hold_data"}, bus.res_data, e.data);
      check({name, ":hold_we"}, 32'(bus.res_we), 32'(e.we));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, ":valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({name, ":ready_back"}, 32'(bus.in_ready), 32'd1);
    $display("[TB] txn %-6s instr=%h data=%h dest=%0d we=%0b taken=%0b illegal=%0b errors=%0d",
             name, ins, bus.res_data, bus.res_dest, bus.res_we, bus.res_taken,
             bus.res_illegal, tests_failed - fails_before);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, ":alu_a"}, alu_a, 32'h0);
    check({tag, ":alu_b"}, alu_b, 32'h0);
    check({tag, ":alu_op"}, 32'(alu_op), 32'h0);
    check({tag, ":res_data"}, bus.res_data, 32'h0);
    check({tag, ":res_dest"}, 32'(bus.res_dest), 32'h0);
    check({tag, ":flags"}, {29'b0, bus.res_we, bus.res_taken, bus.res_illegal}, 32'h0);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.in_pc     = '0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset:in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("release:in_ready", 32'(bus.in_ready), 32'd1);

    run("add",   rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'hFFFF_FFFB, 32'h0, 0);
    run("beq",   itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd7, 32'd7, 32'h40, 0);
    run("bgtz",  itype(6'h07, 5'd1, 5'd0, 16'h0010), 32'h8000_0000, 32'h0, 32'h44, 0);
    run("sra",   rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h03), 32'h0, 32'h8000_0000, 32'h0, 0);
    run("lui",   itype(6'h0F, 5'd0, 5'd6, 16'h1234), 32'h0, 32'h0, 32'h0, 0);
    run("jal",   {6'h03, 26'h0000040}, 32'h0, 32'h0, 32'h100, 0);
    run("sltiu", itype(6'h0B, 5'd1, 5'd7, 16'hFFFF), 32'd1, 32'h0, 32'h0, 0);
    run("sub",   rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h23), 32'd3, 32'd10, 32'h0, 5);
    run("bad3f", rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h3F), 32'h55, 32'h66, 32'h0, 0);
    run("bne",   itype(6'h05, 5'd1, 5'd2, 16'h0004), 32'd7, 32'd8, 32'h0, 0);
    run("blez",  itype(6'h06, 5'd1, 5'd0, 16'h0004), 32'h0, 32'h0, 32'h0, 0);
    run("xori",  itype(6'h0E, 5'd1, 5'd10, 16'hF0F0), 32'hFFFF_0000, 32'h0, 32'h0, 0);
    run("sllv",  rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h04), 32'h0000_0023, 32'h0000_0001, 32'h0, 0);
    run("nor",   rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h27), 32'h0F0F_0000, 32'h0000_00F0, 32'h0, 0);
    run("jalr",  rtype(5'd1, 5'd0, 5'd13, 5'd0, 6'h09), 32'h0, 32'h0, 32'h200, 0);
    run("addi0", itype(6'h08, 5'd1, 5'd0, 16'h8000), 32'd1, 32'h0, 32'h0, 0);
    run("slti",  itype(6'h0A, 5'd1, 5'd2, 16'h0001), 32'd1, 32'h0, 32'h0, 0);

    // Reset while the instruction is in EXEC: it must vanish
    bus.in_instr  = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    bus.in_rs_val = 32'd9;
    bus.in_rt_val = 32'd9;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("exec:alu_a_loaded", alu_a, 32'd9);
    reset = 1'b0;
    @(negedge clk);
    check_zero("exec_rst");
    check("exec_rst:in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("exec_rst:ready_after", 32'(bus.in_ready), 32'd1);
    check("exec_rst:no_valid", 32'(bus.res_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("exec_rst:still_none", 32'(bus.res_valid), 32'd0);
    $display("[TB] txn rstx   reset during EXEC, result discarded errors=%0d", tests_failed);

    run("after", rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h25), 32'h1200_0000, 32'h0000_0034, 32'h0, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
